// File: rtl/call_request_panel.sv
// Holds hall and car button presses as elevator requests and clears each one once it is served.
// Also reports how many requests are pending and flags any request that has waited too long.
module call_request_panel #(
  parameter int WAIT_W   = 6,
  parameter int MAX_WAIT = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] hall_up_press,
  input  logic [2:0] hall_down_press,
  input  logic [3:0] car_press,
  input  logic [2:0] position,
  input  logic       open,
  input  logic [1:0] direction,
  output logic [2:0] button_up,
  output logic [2:0] button_down,
  output logic [3:0] button_in,
  output logic [3:0] pending_count,
  output logic       stale
);
  localparam int NREQ = 10;
  localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);

  // Request vector layout: [2:0] hall up, [5:3] hall down, [9:6] car
  logic [NREQ-1:0] press, prev_q, prev_d, req_q, req_d, set_v, clr_v;
  logic [NREQ-1:0][WAIT_W-1:0] ctr_q, ctr_d;
  logic [3:0] cnt_q, cnt_d;
  logic       stale_q, stale_d;
  logic [1:0] fl;
  logic       served, up_ok, dn_ok;

  assign press = {car_press, hall_down_press, hall_up_press};

  always_comb begin
    clr_v  = '0;
    fl     = position[2:1];
    served = open & ~position[0];
    up_ok  = (direction == 2'b01) || (direction == 2'b00);
    dn_ok  = (direction == 2'b10) || (direction == 2'b00);
    for (int i = 0; i < 3; i++) begin
      if (served && up_ok && fl == 2'(i))     clr_v[i]     = 1'b1;
      if (served && dn_ok && fl == 2'(i + 1)) clr_v[3 + i] = 1'b1;
    end
    for (int i = 0; i < 4; i++)
      if (served && fl == 2'(i)) clr_v[6 + i] = 1'b1;
  end

  always_comb begin
    prev_d  = press;
    set_v   = press & ~prev_q;
    req_d   = (req_q | set_v) & ~clr_v;
    cnt_d   = '0;
    stale_d = 1'b0;
    ctr_d   = '0;
    for (int i = 0; i < NREQ; i++) begin
      cnt_d = cnt_d + 4'(req_d[i]);
      if (req_d[i])
        ctr_d[i] = (ctr_q[i] == MAX_W) ? ctr_q[i] : ctr_q[i] + 1'b1;
      // Looks at the current counters, so stale trails the counter by one edge
      if (ctr_q[i] == MAX_W) stale_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q  <= '0;
      req_q   <= '0;
      ctr_q   <= '0;
      cnt_q   <= '0;
      stale_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      req_q   <= req_d;
      ctr_q   <= ctr_d;
      cnt_q   <= cnt_d;
      stale_q <= stale_d;
    end
  end

  assign button_up     = req_q[2:0];
  assign button_down   = req_q[5:3];
  assign button_in     = req_q[9:6];
  assign pending_count = cnt_q;
  assign stale         = stale_q;
endmodule

// File: tb/tb_call_request_panel.sv
// Directed and random stimulus for call_request_panel, checked against a per-button
// floor/type reference model that tracks each request's set time.
module tb_call_request_panel;
  localparam int MAX_WAIT = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] hall_up_press, hall_down_press;
  logic [3:0] car_press;
  logic [2:0] position;
  logic       open;
  logic [1:0] direction;
  logic [2:0] button_up, button_down;
  logic [3:0] button_in, pending_count;
  logic       stale;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model state
  bit m_req  [10];
  bit m_prev [10];
  int m_set_at [10];
  int cyc;
  bit m_stale;

  call_request_panel #(.WAIT_W(6), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .hall_up_press(hall_up_press), .hall_down_press(hall_down_press), .car_press(car_press),
    .position(position), .open(open), .direction(direction),
    .button_up(button_up), .button_down(button_down), .button_in(button_in),
    .pending_count(pending_count), .stale(stale)
  );

  always #5 clk = ~clk;

  // Button i: kind 0=up,1=down,2=car; its floor (0=1F)
  function automatic int kind_of(int i);
    return (i < 3) ? 0 : (i < 6) ? 1 : 2;
  endfunction
  function automatic int floor_of(int i);
    return (i < 3) ? i : (i < 6) ? i - 2 : i - 6;
  endfunction
  function automatic bit press_of(int i);
    if (i < 3) return hall_up_press[i];
    if (i < 6) return hall_down_press[i - 3];
    return car_press[i - 6];
  endfunction

  function automatic bit served(int i);
    int f;
    if (!(open == 1'b1 && position[0] == 1'b0)) return 0;
    f = int'(position[2:1]);
    if (floor_of(i) != f) return 0;
    case (kind_of(i))
      0: return direction == 2'b00 || direction == 2'b01;
      1: return direction == 2'b00 || direction == 2'b10;
      default: return 1;
    endcase
  endfunction

  task automatic model_edge();
    bit nreq [10];
    cyc++;
    m_stale = 0;
    for (int i = 0; i < 10; i++)
      if (m_req[i] && (cyc - m_set_at[i]) >= MAX_WAIT) m_stale = 1;
    for (int i = 0; i < 10; i++) begin
      bit rise;
      rise = press_of(i) && !m_prev[i];
      nreq[i] = (m_req[i] || rise) && !served(i);
      if (nreq[i] && !m_req[i]) m_set_at[i] = cyc;
      m_prev[i] = press_of(i);
    end
    for (int i = 0; i < 10; i++) m_req[i] = nreq[i];
  endtask

  task automatic model_reset();
    for (int i = 0; i < 10; i++) begin
      m_req[i] = 0; m_prev[i] = 0; m_set_at[i] = 0;
    end
    m_stale = 0;
    cyc = 0;
  endtask

  task automatic check_all();
    logic [2:0] eu, ed;
    logic [3:0] ei, ec;
    ec = '0;
    for (int i = 0; i < 3; i++) begin eu[i] = m_req[i]; ed[i] = m_req[3 + i]; end
    for (int i = 0; i < 4; i++) ei[i] = m_req[6 + i];
    for (int i = 0; i < 10; i++) ec = ec + 4'(m_req[i]);
    n_asserts++;
    assert (button_up === eu) else begin
      n_fail++; $error("FAIL button_up cyc=%0d got=%b exp=%b", cyc, button_up, eu);
    end
    n_asserts++;
    assert (button_down === ed) else begin
      n_fail++; $error("FAIL button_down cyc=%0d got=%b exp=%b", cyc, button_down, ed);
    end
    n_asserts++;
    assert (button_in === ei) else begin
      n_fail++; $error("FAIL button_in cyc=%0d got=%b exp=%b", cyc, button_in, ei);
    end
    n_asserts++;
    assert (pending_count === ec) else begin
      n_fail++; $error("FAIL pending_count cyc=%0d got=%0d exp=%0d", cyc, pending_count, ec);
    end
    n_asserts++;
    assert (stale === m_stale) else begin
      n_fail++; $error("FAIL stale cyc=%0d got=%b exp=%b", cyc, stale, m_stale);
    end
  endtask

  task automatic step(int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (reset) model_reset(); else model_edge();
      #1;
      check_all();
    end
  endtask

  task automatic chk(string tag, logic [3:0] got, logic [3:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++; $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic idle();
    hall_up_press = '0; hall_down_press = '0; car_press = '0;
    open = 1'b0; position = 3'b000; direction = 2'b00;
  endtask

  initial begin
    int st;
    // 1. reset with all buttons held, then release with car 3F held
    reset = 1'b1;
    hall_up_press = '1; hall_down_press = '1; car_press = '1;
    open = 1'b0; position = 3'b000; direction = 2'b00;
    model_reset();
    step(3);
    #1;
    hall_up_press = '0; hall_down_press = '0; car_press = 4'b0100;
    reset = 1'b0;
    step();
    chk("reset_release_in", button_in, 4'b0100);
    chk("reset_release_cnt", pending_count, 4'd1);
    car_press = '0;
    position = 3'b100; open = 1'b1; direction = 2'b00;
    step();
    idle(); step();

    // 2. up 2F and down 2F, serve 2F going up
    hall_up_press[1] = 1'b1; hall_down_press[0] = 1'b1; step();
    hall_up_press = '0; hall_down_press = '0; step();
    chk("t2_cnt_before", pending_count, 4'd2);
    position = 3'b010; open = 1'b1; direction = 2'b01; step();
    chk("t2_up", {1'b0, button_up}, 4'b0000);
    chk("t2_down", {1'b0, button_down}, 4'b0001);
    chk("t2_cnt_after", pending_count, 4'd1);
    direction = 2'b10; step();
    idle(); step();

    // 3. three requests at 3F served together with direction stop
    hall_up_press[2] = 1'b1; hall_down_press[1] = 1'b1; car_press[2] = 1'b1; step();
    idle(); step(2);
    position = 3'b100; open = 1'b1; direction = 2'b00; step();
    chk("t3_cnt", pending_count, 4'd0);
    idle(); step();

    // 4. car 1F held across set and serve: one set only until re-pressed
    car_press[0] = 1'b1; step();
    chk("t4_set", button_in, 4'b0001);
    position = 3'b000; open = 1'b1; step(4);
    open = 1'b0; step(5);
    chk("t4_no_reset", button_in, 4'b0000);
    car_press[0] = 1'b0; step();
    car_press[0] = 1'b1; step();
    chk("t4_repress", button_in, 4'b0001);
    car_press[0] = 1'b0; open = 1'b1; step();
    idle(); step();

    // 5. stale timing: count edges from the set edge to stale rising
    car_press[3] = 1'b1; step();
    car_press[3] = 1'b0;
    st = 0;
    while (stale !== 1'b1 && st < 60) begin step(); st++; end
    chk("t5_stale_rise_cycles", 4'(st == MAX_WAIT), 4'd1);
    position = 3'b110; open = 1'b1; step();
    chk("t5_stale_hold", {3'b0, stale}, 4'd1);
    idle(); step();
    chk("t5_stale_fall", {3'b0, stale}, 4'd0);

    // 6. rise coincides with clear; between floors clears nothing
    position = 3'b010; open = 1'b1; direction = 2'b00;
    car_press[1] = 1'b1; step();
    chk("t6_clear_wins", button_in, 4'b0000);
    idle(); car_press[2] = 1'b1; hall_up_press[1] = 1'b1; step();
    idle(); position = 3'b011; open = 1'b1; step(2);
    chk("t6_between", pending_count, 4'd2);
    position = 3'b100; direction = 2'b11; step();
    chk("t6_illegal_dir", pending_count, 4'd1);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 7) == 0) hall_up_press[i] = ~hall_up_press[i];
        if ($urandom_range(0, 7) == 0) hall_down_press[i] = ~hall_down_press[i];
      end
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 7) == 0) car_press[i] = ~car_press[i];
      position  = 3'($urandom_range(0, 7));
      open      = ($urandom_range(0, 5) == 0);
      direction = 2'($urandom_range(0, 3));
      step();
    end

    // Reset mid-run with buttons held
    #1; reset = 1'b1; hall_up_press = '1; step(2);
    #1; reset = 1'b0; step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
